// File: rtl/wb_unit.sv
// Writeback unit: captures one instruction, waits for memory data on loads,
// then writes the register file and pulses retire while counting retirements.
module wb_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_is_load,
  input  logic                       in_is_csr,
  input  logic                       in_rd_wen,
  input  logic [4:0]                 in_rd_idx,
  input  logic [XLEN-1:0]            in_alu_res,
  input  logic [XLEN-1:0]            in_csr_rdata,
  input  logic [2:0]                 in_ld_funct3,
  input  logic [$clog2(XLEN/8)-1:0]  in_ld_off,
  input  logic                       mem_rvalid,
  input  logic [XLEN-1:0]            mem_rdata,
  output logic                       rf_wen,
  output logic [4:0]                 rf_idx,
  output logic [XLEN-1:0]            rf_wdata,
  output logic                       retire,
  output logic [CNT_W-1:0]           retire_cnt
);

  localparam int OFF_W = $clog2(XLEN/8);

  typedef enum logic {
    IDLE,
    WAIT_MEM
  } state_t;

  state_t state;

  logic             accept;
  logic             cap_wr_en;
  logic [4:0]       cap_rd_idx;
  logic [2:0]       cap_funct3;
  logic [OFF_W-1:0] cap_off;
  logic             in_wr_en;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  // Writes to x0 are suppressed but the instruction still retires.
  assign in_wr_en = in_rd_wen && (in_rd_idx != 5'd0);

  // Align the addressed bytes to bit 0, then size and extend them.
  // Unsupported size codes (and 64-bit-only codes on a 32-bit datapath) yield zero.
  function automatic logic [XLEN-1:0] load_extract(
    input logic [XLEN-1:0]  raw,
    input logic [2:0]       funct3,
    input logic [OFF_W-1:0] off
  );
    logic [XLEN-1:0] sh;
    sh = raw >> {off, 3'b000};
    // NOTE: default assigned first so every path through the case drives the
    // result; without it the combinational logic would infer a latch.
    load_extract = '0;
    case (funct3)
      3'b000: load_extract = XLEN'($signed(sh[7:0]));
      3'b001: load_extract = XLEN'($signed(sh[15:0]));
      3'b010: load_extract = XLEN'($signed(sh[31:0]));
      3'b100: load_extract = XLEN'(sh[7:0]);
      3'b101: load_extract = XLEN'(sh[15:0]);
      3'b011: if (XLEN == 64) load_extract = sh;
      3'b110: if (XLEN == 64) load_extract = XLEN'(sh[31:0]);
      default: load_extract = '0;
    endcase
  endfunction

  // NOTE: these capture registers are deliberately not reset; they are only
  // read in WAIT_MEM, which is unreachable without a fresh acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      cap_wr_en  <= in_wr_en;
      cap_rd_idx <= in_rd_idx;
      cap_funct3 <= in_ld_funct3;
      cap_off    <= in_ld_off;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rf_wen     <= 1'b0;
      retire     <= 1'b0;
      rf_idx     <= '0;
      rf_wdata   <= '0;
      retire_cnt <= '0;
    end else begin
      rf_wen <= 1'b0;
      retire <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (in_is_load) begin
              state <= WAIT_MEM;
            end else begin
              retire     <= 1'b1;
              retire_cnt <= retire_cnt + CNT_W'(1);
              if (in_wr_en) begin
                rf_wen   <= 1'b1;
                rf_idx   <= in_rd_idx;
                rf_wdata <= in_is_csr ? in_csr_rdata : in_alu_res;
              end
            end
          end
        end
        WAIT_MEM: begin
          if (mem_rvalid) begin
            state      <= IDLE;
            retire     <= 1'b1;
            retire_cnt <= retire_cnt + CNT_W'(1);
            if (cap_wr_en) begin
              rf_wen   <= 1'b1;
              rf_idx   <= cap_rd_idx;
              rf_wdata <= load_extract(mem_rdata, cap_funct3, cap_off);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_wen_implies_retire : assert property (@(posedge clk) disable iff (!rst_n)
    rf_wen |-> retire);
  a_retire_single_pulse : assert property (@(posedge clk) disable iff (!rst_n)
    retire |=> !retire || $past(in_ready));

endmodule

// File: tb/tb_wb_unit.sv
// Bench for wb_unit: 32-bit, 64-bit and 4-bit-counter instances share one stimulus
// stream; expectations come from a hand table and a behavioural load/writeback model.
module tb_wb_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_is_load = 1'b0, in_is_csr = 1'b0, in_rd_wen = 1'b0;
  logic [4:0]  in_rd_idx = '0;
  logic [63:0] in_alu_res = '0, in_csr_rdata = '0, mem_rdata = '0;
  logic [2:0]  in_ld_funct3 = '0, in_ld_off = '0;
  logic        mem_rvalid = 1'b0;

  logic        rdy32, wen32, ret32;
  logic [4:0]  idx32;
  logic [31:0] wd32;
  logic [63:0] cnt32;
  logic        rdy64, wen64, ret64;
  logic [4:0]  idx64;
  logic [63:0] wd64;
  logic [63:0] cnt64;
  logic        rdy4, wen4, ret4;
  logic [4:0]  idx4;
  logic [31:0] wd4;
  logic [3:0]  cnt4;

  always #5 clk = ~clk;

  wb_unit #(.XLEN(32), .CNT_W(64)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
    .in_is_load(in_is_load), .in_is_csr(in_is_csr), .in_rd_wen(in_rd_wen),
    .in_rd_idx(in_rd_idx), .in_alu_res(in_alu_res[31:0]), .in_csr_rdata(in_csr_rdata[31:0]),
    .in_ld_funct3(in_ld_funct3), .in_ld_off(in_ld_off[1:0]), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata[31:0]), .rf_wen(wen32), .rf_idx(idx32), .rf_wdata(wd32),
    .retire(ret32), .retire_cnt(cnt32));

  wb_unit #(.XLEN(64), .CNT_W(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64),
    .in_is_load(in_is_load), .in_is_csr(in_is_csr), .in_rd_wen(in_rd_wen),
    .in_rd_idx(in_rd_idx), .in_alu_res(in_alu_res), .in_csr_rdata(in_csr_rdata),
    .in_ld_funct3(in_ld_funct3), .in_ld_off(in_ld_off), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .rf_wen(wen64), .rf_idx(idx64), .rf_wdata(wd64),
    .retire(ret64), .retire_cnt(cnt64));

  wb_unit #(.XLEN(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy4),
    .in_is_load(in_is_load), .in_is_csr(in_is_csr), .in_rd_wen(in_rd_wen),
    .in_rd_idx(in_rd_idx), .in_alu_res(in_alu_res[31:0]), .in_csr_rdata(in_csr_rdata[31:0]),
    .in_ld_funct3(in_ld_funct3), .in_ld_off(in_ld_off[1:0]), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata[31:0]), .rf_wen(wen4), .rf_idx(idx4), .rf_wdata(wd4),
    .retire(ret4), .retire_cnt(cnt4));

  typedef struct {
    bit        is_load;
    bit        is_csr;
    bit        rd_wen;
    bit [4:0]  rd;
    bit [63:0] alu;
    bit [63:0] csr;
    bit [63:0] mem;
    bit [2:0]  f3;
    bit [2:0]  off;
    int        waits;
    bit        early_rv;
    bit [31:0] exp32;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  logic [63:0] cnt_model = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] sext(input logic [63:0] x, input int bits);
    logic [63:0] span, v;
    span = 64'd1 << bits;
    v = x & (span - 64'd1);
    if (v >= (span >> 1)) v = v - span;
    return v;
  endfunction

  // Writeback value an instruction should produce on a datapath xlen bits wide.
  function automatic logic [63:0] ref_wdata(input int xlen, input vec_t v);
    logic [63:0] d, s, r;
    int o;
    if (!v.is_load) begin
      r = v.is_csr ? v.csr : v.alu;
    end else begin
      d = (xlen == 32) ? (v.mem & 64'hFFFF_FFFF) : v.mem;
      o = (xlen == 32) ? (int'(v.off) % 4) : int'(v.off);
      s = d >> (8 * o);
      case (v.f3)
        3'd0: r = sext(s, 8);
        3'd1: r = sext(s, 16);
        3'd2: r = sext(s, 32);
        3'd4: r = s & 64'hFF;
        3'd5: r = s & 64'hFFFF;
        3'd3: r = (xlen == 64) ? s : 64'd0;
        3'd6: r = (xlen == 64) ? (s & 64'hFFFF_FFFF) : 64'd0;
        default: r = 64'd0;
      endcase
    end
    return (xlen == 32) ? (r & 64'hFFFF_FFFF) : r;
  endfunction

  task automatic check_retire(input vec_t v, input logic [63:0] e32, input logic [63:0] e64);
    bit ew;
    ew = v.rd_wen && (v.rd != 5'd0);
    cnt_model++;
    check("retire32", ret32, 1);
    check("retire64", ret64, 1);
    check("retire_w4", ret4, 1);
    check("rf_wen32", wen32, ew);
    check("rf_wen64", wen64, ew);
    if (ew) begin
      check("rf_idx32", idx32, v.rd);
      check("rf_idx64", idx64, v.rd);
      check("rf_wdata32", wd32, e32);
      check("rf_wdata64", wd64, e64);
    end
    check("retire_cnt32", cnt32, cnt_model);
    check("retire_cnt64", cnt64, cnt_model);
    check("retire_cnt_w4", cnt4, cnt_model & 64'hF);
    check("ready_after_retire", rdy32, 1);
  endtask

  task automatic check_quiet(input string name);
    check({name, "_retire"}, ret32 | ret64 | ret4, 0);
    check({name, "_wen"}, wen32 | wen64 | wen4, 0);
  endtask

  task automatic issue(input vec_t v, input bit from_table);
    int k;
    k = 0;
    while (!rdy32 && k < 20) begin
      tick();
      k++;
    end
    check("ready_before_issue", rdy32 & rdy64, 1);
    in_valid     = 1'b1;
    in_is_load   = v.is_load;
    in_is_csr    = v.is_csr;
    in_rd_wen    = v.rd_wen;
    in_rd_idx    = v.rd;
    in_alu_res   = v.alu;
    in_csr_rdata = v.csr;
    in_ld_funct3 = v.f3;
    in_ld_off    = v.off;
    mem_rvalid   = v.early_rv;
    mem_rdata    = ~v.mem;
    tick();
    in_valid   = 1'b0;
    mem_rvalid = 1'b0;
    in_alu_res = ~v.alu;
    in_rd_idx  = ~v.rd;
    in_ld_off  = ~v.off;
    if (v.is_load) begin
      for (int i = 0; i < v.waits; i++) begin
        check("wait_ready", rdy32 | rdy64, 0);
        check_quiet("wait");
        tick();
      end
      check("rvalid_cycle_ready", rdy32 | rdy64, 0);
      mem_rvalid = 1'b1;
      mem_rdata  = v.mem;
      tick();
      mem_rvalid = 1'b0;
      mem_rdata  = ~v.mem;
    end
    check_retire(v, from_table ? 64'(v.exp32) : ref_wdata(32, v), ref_wdata(64, v));
  endtask

  vec_t tab[$];
  vec_t v;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // is_load, is_csr, rd_wen, rd, alu, csr, mem, f3, off, waits, early_rv, exp32
    tab.push_back('{0, 0, 1, 5'd1, 64'h11, 64'h0, 64'h0, 3'd0, 3'd0, 0, 0, 32'h11});
    tab.push_back('{0, 0, 1, 5'd2, 64'h22, 64'h0, 64'h0, 3'd0, 3'd0, 0, 0, 32'h22});
    tab.push_back('{0, 0, 1, 5'd3, 64'h33, 64'h0, 64'h0, 3'd0, 3'd0, 0, 0, 32'h33});
    tab.push_back('{1, 0, 1, 5'd5, 64'h0, 64'h0, 64'h80FF_FFFF, 3'd0, 3'd3, 2, 0, 32'hFFFF_FF80});
    tab.push_back('{1, 0, 1, 5'd6, 64'h0, 64'h0, 64'h8001_0000, 3'd5, 3'd2, 0, 0, 32'h0000_8001});
    tab.push_back('{0, 1, 1, 5'd0, 64'h99, 64'h5, 64'h0, 3'd0, 3'd0, 0, 0, 32'h5});
    tab.push_back('{0, 1, 1, 5'd7, 64'h1234, 64'hDEAD_BEEF, 64'h0, 3'd0, 3'd0, 0, 0, 32'hDEAD_BEEF});
    tab.push_back('{0, 0, 0, 5'd9, 64'h77, 64'h0, 64'h0, 3'd0, 3'd0, 0, 0, 32'h77});
    tab.push_back('{1, 0, 1, 5'd10, 64'h0, 64'h0, 64'h8000_0001, 3'd2, 3'd0, 1, 1, 32'h8000_0001});
    tab.push_back('{1, 0, 1, 5'd11, 64'h0, 64'h0, 64'h0000_F000, 3'd4, 3'd1, 0, 1, 32'h0000_00F0});
    tab.push_back('{1, 0, 1, 5'd12, 64'h0, 64'h0, 64'h0000_8123, 3'd1, 3'd0, 1, 0, 32'hFFFF_8123});
    tab.push_back('{1, 0, 1, 5'd4, 64'h0, 64'h0, 64'hFFFF_FFFF, 3'd7, 3'd0, 0, 0, 32'h0});
    tab.push_back('{1, 0, 1, 5'd13, 64'h0, 64'h0, 64'h1234_5678, 3'd3, 3'd0, 0, 0, 32'h0});
    tab.push_back('{1, 0, 1, 5'd14, 64'h0, 64'h0, 64'h8765_4321, 3'd6, 3'd0, 0, 0, 32'h0});

    // Reset with garbage on the inputs: nothing may be accepted or retired.
    in_valid   = 1'b1;
    mem_rvalid = 1'b1;
    repeat (3) tick();
    in_valid   = 1'b0;
    mem_rvalid = 1'b0;
    check("reset_ready", rdy32 & rdy64 & rdy4, 1);
    check_quiet("reset");
    check("reset_idx", idx32, 0);
    check("reset_wdata", wd64, 0);
    check("reset_cnt", cnt64 | cnt32, 0);
    rst_n = 1'b1;
    tick();
    check_quiet("post_reset");

    for (int i = 0; i < tab.size(); i++) begin
      issue(tab[i], 1'b1);
      if (i == 2) check("cnt_after_three_alu", cnt32, 3);
    end
    tick();
    check_quiet("idle_after_table");

    // Memory data arriving while idle must be ignored.
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    mem_rvalid = 1'b0;
    check_quiet("idle_rvalid");
    check("idle_rvalid_ready", rdy32 & rdy64, 1);

    for (int n = 0; n < 250; n++) begin
      v.is_load  = $urandom_range(1, 0) == 1;
      v.is_csr   = $urandom_range(1, 0) == 1;
      v.rd_wen   = $urandom_range(3, 0) != 0;
      v.rd       = 5'($urandom_range(31, 0));
      v.alu      = {$urandom, $urandom};
      v.csr      = {$urandom, $urandom};
      v.mem      = {$urandom, $urandom};
      v.f3       = 3'($urandom_range(7, 0));
      v.off      = 3'($urandom_range(7, 0));
      v.waits    = $urandom_range(3, 0);
      v.early_rv = $urandom_range(1, 0) == 1;
      v.exp32    = '0;
      issue(v, 1'b0);
      if ($urandom_range(3, 0) == 0) begin
        tick();
        check_quiet("rand_gap");
      end
    end

    // Reset while a load is pending, with memory data arriving on the reset edge.
    v = '{1, 0, 1, 5'd8, 64'h0, 64'h0, 64'h0, 3'd2, 3'd0, 0, 0, 32'h0};
    in_valid     = 1'b1;
    in_is_load   = 1'b1;
    in_rd_wen    = 1'b1;
    in_rd_idx    = v.rd;
    in_ld_funct3 = v.f3;
    tick();
    in_valid = 1'b0;
    tick();
    check("pending_load_ready", rdy32 | rdy64, 0);
    rst_n      = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h5555_5555_5555_5555;
    in_valid   = 1'b1;
    tick();
    rst_n      = 1'b1;
    mem_rvalid = 1'b0;
    in_valid   = 1'b0;
    cnt_model  = '0;
    check_quiet("reset_in_wait");
    check("reset_in_wait_cnt", cnt32 | cnt64, 0);
    check("reset_in_wait_ready", rdy32 & rdy64, 1);
    tick();
    check_quiet("after_reset_in_wait");
    check("after_reset_in_wait_ready", rdy32 & rdy64, 1);
    check("after_reset_in_wait_cnt", cnt32, 0);

    // Seventeen retirements wrap the 4-bit counter to one.
    for (int n = 0; n < 17; n++) begin
      v = '{0, 0, 1, 5'(n + 1), 64'(n * 3 + 1), 64'h0, 64'h0, 3'd0, 3'd0, 0, 0, 32'(n * 3 + 1)};
      issue(v, 1'b1);
    end
    check("wrap_cnt_w4", cnt4, 1);
    check("wrap_cnt32", cnt32, 17);
    tick();
    check_quiet("final_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_unit.md
WB_UNIT -- requirements
Module: wb_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter CNT_W, default 64, width of the retire counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; synchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  upstream holds a valid instruction.
REQ-006 SHALL have port in_ready  output  1  unit accepts the instruction this cycle.
REQ-007 SHALL have port in_is_load  input  1  instruction result comes from memory.
REQ-008 SHALL have port in_is_csr  input  1  instruction result is the CSR read data.
REQ-009 SHALL have port in_rd_wen  input  1  instruction writes rd.
REQ-010 SHALL have port in_rd_idx  input  5  destination register index.
REQ-011 SHALL have port in_alu_res  input  XLEN  ALU result.
REQ-012 SHALL have port in_csr_rdata  input  XLEN  CSR old value.
REQ-013 SHALL have port in_ld_funct3  input  3  load size/sign code.
REQ-014 SHALL have port in_ld_off  input  $clog2(XLEN/8)  byte offset of the load within the memory word.
REQ-015 SHALL have port mem_rvalid  input  1  memory read data valid (one-cycle pulse).
REQ-016 SHALL have port mem_rdata  input  XLEN  raw aligned memory word.
REQ-017 SHALL have port rf_wen  output  1  register-file write enable.
REQ-018 SHALL have port rf_idx  output  5  register-file write index.
REQ-019 SHALL have port rf_wdata  output  XLEN  register-file write data.
REQ-020 SHALL have port retire  output  1  one-cycle pulse per completed instruction.
REQ-021 SHALL have port retire_cnt  output  CNT_W  count of completed instructions.

Function
REQ-022 SHALL implement states IDLE and WAIT_MEM; in_ready = (state==IDLE), combinational from state only.
REQ-023 SHALL accept an instruction when in_valid && in_ready; inputs are captured into internal registers at acceptance.
REQ-024 SHALL, on accepting a non-load, drive rf_wen/rf_idx/rf_wdata/retire in the next cycle and stay in IDLE; a new instruction may be accepted every cycle.
REQ-025 SHALL select write data for non-loads: in_is_csr ? in_csr_rdata : in_alu_res.
REQ-026 SHALL, on accepting a load, go to WAIT_MEM; in_ready=0 until mem_rvalid.
REQ-027 SHALL, in WAIT_MEM with mem_rvalid=1, drive the load write/retire in the next cycle and return to IDLE in that same next cycle.
REQ-028 SHALL NOT complete a load in its acceptance cycle; mem_rvalid coincident with load acceptance is ignored.
REQ-029 SHALL ignore mem_rvalid in IDLE.
REQ-030 SHALL extract load data as mem_rdata >> (8*in_ld_off), then: 000 LB sign-extend 8b; 001 LH sign-extend 16b; 010 LW sign-extend 32b; 100 LBU, 101 LHU zero-extend; XLEN=64 only: 011 LD full 64b, 110 LWU zero-extend 32b.
REQ-031 SHALL treat unsupported funct3 codes as zero write data; the instruction still retires.
REQ-032 SHALL assert rf_wen only if captured in_rd_wen=1 and rd_idx!=0; rd_idx=0 still retires.
REQ-033 SHALL hold rf_wen and retire high exactly one cycle per instruction; rf_idx/rf_wdata hold their last value otherwise.
REQ-034 SHALL increment retire_cnt by 1 in the cycle retire is high, wrapping from all-ones to 0.

Reset
REQ-035 SHALL, when rst_n=0 at a clock edge, set state=IDLE, rf_wen=0, retire=0, rf_idx=0, rf_wdata=0, retire_cnt=0.
REQ-036 SHALL, on reset during WAIT_MEM, drop the pending load: no write, no retire, in_ready=1 in the cycle after reset deasserts.
REQ-037 SHALL ignore in_valid and mem_rvalid while rst_n=0.

Verification
REQ-038 SHALL cover: three back-to-back ALU ops rd=1,2,3 data 0x11,0x22,0x33 -> rf_wen high cycles 1-3 with matching idx/data, retire_cnt=3.
REQ-039 SHALL cover: LB off=3, mem_rdata=0x80FF_FFFF after 2 wait cycles -> in_ready low 3 cycles, rf_wdata=0xFFFF_FF80.
REQ-040 SHALL cover: LHU off=2, mem_rdata=0x8001_0000 -> rf_wdata=0x0000_8001.
REQ-041 SHALL cover: CSR op rd=0, csr_rdata=0x5 -> rf_wen=0, retire=1, retire_cnt increments.
REQ-042 SHALL cover: reset asserted in WAIT_MEM with mem_rvalid same cycle -> no rf_wen, retire_cnt=0, in_ready=1 after release.
REQ-043 SHALL cover: CNT_W=4, 17 retirements -> retire_cnt=1 (wrap).
